rns2bin_32_31_21_5: RTL and testbench

RNS2BIN_32_31_21_5 -- requirements
Module: rns2bin_32_31_21_5

---
 rtl/rns_pkg.sv | 49 ++++
 rtl/rns2bin_32_31_21_5_mod_sub_const.sv | 25 ++
 rtl/rns2bin_32_31_21_5.sv | 159 +++++++++++++++
 tb/tb_rns2bin_32_31_21_5.sv | 125 ++++++++++++
 4 files changed

// File: rtl/rns_pkg.sv
// Shared constants and types for the residue-number-system to binary converter.
//   Moduli set {32, 31, 21, 5}, dynamic range 104160 (17-bit binary result).
//   Mixed-radix weights 32, 992, 20832 and the modular inverses of the
//   weights used by digits 3 and 4: 992^-1 mod 21 = 17, 20832^-1 mod 5 = 3.
//   mod_red() reduces a value modulo a small constant by restoring
//   subtraction, so no divider is ever inferred.
package rns_pkg;

   localparam int DYN_BITS = 17;

   localparam int M1 = 32;
   localparam int M2 = 31;
   localparam int M3 = 21;
   localparam int M4 = 5;

   localparam int R1_W = 5;
   localparam int R2_W = 5;
   localparam int R3_W = 5;
   localparam int R4_W = 3;

   localparam logic [DYN_BITS-1:0] W2   = 17'd32;
   localparam logic [DYN_BITS-1:0] W3   = 17'd992;
   localparam logic [DYN_BITS-1:0] W4   = 17'd20832;
   localparam logic [DYN_BITS-1:0] INV3 = 17'd17;
   localparam logic [DYN_BITS-1:0] INV4 = 17'd3;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      S_A2  = 3'd1,
      S_A3  = 3'd2,
      S_A4  = 3'd3,
      S_OUT = 3'd4
   } state_e;

   // v mod m by subtracting m shifted down from the top bit; with m constant
   // this collapses to a chain of compare/subtract stages.
   function automatic logic [DYN_BITS-1:0] mod_red(input logic [DYN_BITS-1:0] v,
                                                    input int m);
      logic [DYN_BITS-1:0] acc;
      logic [31:0]         mk;
      acc = v;
      for (int k = DYN_BITS - 1; k >= 0; k--) begin
         mk = 32'(m) << k;
         if (mk <= 32'(acc)) acc = acc - mk[DYN_BITS-1:0];
      end
      return acc;
   endfunction

endpackage

// File: rtl/rns2bin_32_31_21_5_mod_sub_const.sv
// mod_sub_const: combinational (a - b) mod M for a constant modulus M.
//   a, b : unsigned operands of any value in DYN_BITS; both are reduced mod M first
//   d    : result in 0..M-1 (zero-extended to DYN_BITS)
// A negative difference is corrected by adding M once.
module mod_sub_const
   import rns_pkg::*;
#(
   parameter int M = 31
) (
   input  logic [DYN_BITS-1:0] a,
   input  logic [DYN_BITS-1:0] b,
   output logic [DYN_BITS-1:0] d
);

   logic [DYN_BITS-1:0] a_red;
   logic [DYN_BITS-1:0] b_red;

   always_comb begin
      a_red = mod_red(a, M);
      b_red = mod_red(b, M);
      if (a_red >= b_red) d = a_red - b_red;
      else                d = a_red + DYN_BITS'(M) - b_red;
   end

endmodule

// File: rtl/rns2bin_32_31_21_5.sv
// rns2bin_32_31_21_5: converts a residue tuple (mod 32, 31, 21, 5) to binary
// by mixed-radix conversion, one digit per clock:
//   X = a1 + 32*a2 + 992*a3 + 20832*a4
// Ports:
//   clk, reset (async, active-high)
//   in_valid/in_ready, in_r1..in_r4 : residue tuple handshake (ready only in IDLE)
//   out_valid/out_ready, out_bin, out_err : result handshake, held until taken
// Build option RNS2BIN_RANGE_CHECK_EN: out-of-range residues give out_err = 1
// and out_bin = 0. Without it out_err is tied low and an out-of-range residue
// is folded once by subtracting its modulus before conversion.
module rns2bin_32_31_21_5
   import rns_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [R1_W-1:0]     in_r1,
   input  logic [R2_W-1:0]     in_r2,
   input  logic [R3_W-1:0]     in_r3,
   input  logic [R4_W-1:0]     in_r4,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DYN_BITS-1:0] out_bin,
   output logic                out_err
);

   state_e              state_q, state_d;
   logic [R1_W-1:0]     r1_q, r1_d;
   logic [R2_W-1:0]     r2_q, r2_d;
   logic [R3_W-1:0]     r3_q, r3_d;
   logic [R4_W-1:0]     r4_q, r4_d;
   // Running partial sum: P2 after S_A2, P3 after S_A3.
   logic [DYN_BITS-1:0] p_q, p_d;
   logic [DYN_BITS-1:0] out_bin_q, out_bin_d;

   logic [DYN_BITS-1:0] d31, d21, d5;
   logic [DYN_BITS-1:0] a3, a4, x_full;

   mod_sub_const #(.M(M2)) u_sub31 (
      .a (DYN_BITS'(r2_q)),
      .b (DYN_BITS'(r1_q)),
      .d (d31)
   );

   mod_sub_const #(.M(M3)) u_sub21 (
      .a (DYN_BITS'(r3_q)),
      .b (p_q),
      .d (d21)
   );

   mod_sub_const #(.M(M4)) u_sub5 (
      .a (DYN_BITS'(r4_q)),
      .b (p_q),
      .d (d5)
   );

   always_comb begin
      a3     = mod_red(d21 * INV3, M3);
      a4     = mod_red(d5 * INV4, M4);
      x_full = p_q + a4 * W4;
   end

`ifdef RNS2BIN_RANGE_CHECK_EN
   logic err_q, err_d;
   logic out_err_q, out_err_d;
`endif

   always_comb begin
      state_d   = state_q;
      r1_d      = r1_q;
      r2_d      = r2_q;
      r3_d      = r3_q;
      r4_d      = r4_q;
      p_d       = p_q;
      out_bin_d = out_bin_q;
`ifdef RNS2BIN_RANGE_CHECK_EN
      err_d     = err_q;
      out_err_d = out_err_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               r1_d    = in_r1;
`ifdef RNS2BIN_RANGE_CHECK_EN
               r2_d    = in_r2;
               r3_d    = in_r3;
               r4_d    = in_r4;
               err_d   = (in_r2 >= 5'd31) || (in_r3 >= 5'd21) || (in_r4 >= 3'd5);
`else
               r2_d    = (in_r2 >= 5'd31) ? in_r2 - 5'd31 : in_r2;
               r3_d    = (in_r3 >= 5'd21) ? in_r3 - 5'd21 : in_r3;
               r4_d    = (in_r4 >= 3'd5)  ? in_r4 - 3'd5  : in_r4;
`endif
               state_d = S_A2;
            end
         end
         S_A2: begin
            p_d     = DYN_BITS'(r1_q) + d31 * W2;
            state_d = S_A3;
         end
         S_A3: begin
            p_d     = p_q + a3 * W3;
            state_d = S_A4;
         end
         S_A4: begin
`ifdef RNS2BIN_RANGE_CHECK_EN
            out_bin_d = err_q ? '0 : x_full;
            out_err_d = err_q;
`else
            out_bin_d = x_full;
`endif
            state_d   = S_OUT;
         end
         S_OUT: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         r1_q      <= '0;
         r2_q      <= '0;
         r3_q      <= '0;
         r4_q      <= '0;
         p_q       <= '0;
         out_bin_q <= '0;
`ifdef RNS2BIN_RANGE_CHECK_EN
         err_q     <= 1'b0;
         out_err_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         r1_q      <= r1_d;
         r2_q      <= r2_d;
         r3_q      <= r3_d;
         r4_q      <= r4_d;
         p_q       <= p_d;
         out_bin_q <= out_bin_d;
`ifdef RNS2BIN_RANGE_CHECK_EN
         err_q     <= err_d;
         out_err_q <= out_err_d;
`endif
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == S_OUT);
   assign out_bin   = out_bin_q;
`ifdef RNS2BIN_RANGE_CHECK_EN
   assign out_err   = out_err_q;
`else
   assign out_err   = 1'b0;
`endif

endmodule

// File: tb/tb_rns2bin_32_31_21_5.sv
module tb_rns2bin_32_31_21_5;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [4:0]  in_r1 = '0;
   logic [4:0]  in_r2 = '0;
   logic [4:0]  in_r3 = '0;
   logic [2:0]  in_r4 = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [16:0] out_bin;
   logic        out_err;

   int n_cmp = 0;
   int n_err = 0;

   rns2bin_32_31_21_5 dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_r1     (in_r1),
      .in_r2     (in_r2),
      .in_r3     (in_r3),
      .in_r4     (in_r4),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_bin   (out_bin),
      .out_err   (out_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Applies one tuple, checks latency, result, hold under backpressure,
   // the transfer, and that out_bin keeps its value once out_valid drops.
   task automatic apply(input string tag, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] r3, input logic [2:0] r4,
                        input logic [16:0] eb, input logic ee,
                        input int hold, input bit rel_reset);
      @(negedge clk);
      if (rel_reset) reset = 1'b0;
      in_r1 = r1; in_r2 = r2; in_r3 = r3; in_r4 = r4;
      in_valid = 1'b1;
      @(posedge clk); #1;
      chk({tag, "_accept"}, 32'(in_ready), 32'd0);
      in_valid = 1'b0;
      in_r1 = 5'd17; in_r2 = 5'd3; in_r3 = 5'd9; in_r4 = 3'd2;
      @(posedge clk); #1;
      chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      chk({tag, "_lat2"}, 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      chk({tag, "_lat3"}, 32'(out_valid), 32'd1);
      chk({tag, "_bin"},  32'(out_bin),   32'(eb));
      chk({tag, "_err"},  32'(out_err),   32'(ee));
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk({tag, "_hold_vld"}, 32'(out_valid), 32'd1);
         chk({tag, "_hold_bin"}, 32'(out_bin),   32'(eb));
         chk({tag, "_hold_err"}, 32'(out_err),   32'(ee));
         chk({tag, "_hold_rdy"}, 32'(in_ready),  32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "_done_vld"}, 32'(out_valid), 32'd0);
      chk({tag, "_done_rdy"}, 32'(in_ready),  32'd1);
      chk({tag, "_keep_bin"}, 32'(out_bin),   32'(eb));
   endtask

   initial begin
      logic [16:0] e31_bin;
      logic        e31_err;
`ifdef RNS2BIN_RANGE_CHECK_EN
      e31_bin = 17'd0; e31_err = 1'b1;
`else
      e31_bin = 17'd0; e31_err = 1'b0;
`endif
      #12;
      chk("rst_rdy", 32'(in_ready),  32'd1);
      chk("rst_vld", 32'(out_valid), 32'd0);
      chk("rst_bin", 32'(out_bin),   32'd0);
      chk("rst_err", 32'(out_err),   32'd0);

      apply("zero",   5'd0,  5'd0,  5'd0,  3'd0, 17'd0,      1'b0, 0, 1'b1);
      apply("v12345", 5'd25, 5'd7,  5'd18, 3'd0, 17'd12345,  1'b0, 0, 1'b0);
      apply("max",    5'd31, 5'd30, 5'd20, 3'd4, 17'd104159, 1'b0, 0, 1'b0);
      apply("one",    5'd1,  5'd1,  5'd1,  3'd1, 17'd1,      1'b0, 0, 1'b0);
      apply("v100",   5'd4,  5'd7,  5'd16, 3'd0, 17'd100,    1'b0, 0, 1'b0);
      apply("maxm1",  5'd30, 5'd29, 5'd19, 3'd3, 17'd104158, 1'b0, 0, 1'b0);
      apply("bp",     5'd25, 5'd7,  5'd18, 3'd0, 17'd12345,  1'b0, 5, 1'b0);
      apply("r2ill",  5'd0,  5'd31, 5'd0,  3'd0, e31_bin,    e31_err, 0, 1'b0);

      // Reset pulsed while the converter is in S_A3.
      @(negedge clk);
      in_r1 = 5'd31; in_r2 = 5'd30; in_r3 = 5'd20; in_r4 = 3'd4;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      chk("midrst_rdy", 32'(in_ready),  32'd1);
      chk("midrst_vld", 32'(out_valid), 32'd0);
      chk("midrst_bin", 32'(out_bin),   32'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("midrst_vld2", 32'(out_valid), 32'd0);
      apply("after_rst", 5'd25, 5'd7, 5'd18, 3'd0, 17'd12345, 1'b0, 0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
